// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: BTB command codes, fetch step
// and the optional 2-bit branch history counter type.
package bp_pkg;

    typedef enum logic [1:0] {
        BTB_CMD_NONE   = 2'b00,
        BTB_CMD_INVAL  = 2'b01,
        BTB_CMD_INSERT = 2'b10
    } btb_cmd_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t BHT_CTR_RST = 2'b01;
    localparam bht_ctr_t BHT_CTR_INS = 2'b10;

    function automatic bht_ctr_t bht_inc(input bht_ctr_t c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic bht_ctr_t bht_dec(input bht_ctr_t c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_entry_ram.sv
// Direct-mapped BTB storage: one combinational lookup port, one synchronous
// update port. Optional per-entry 2-bit counter when BTB_BHT_EN is defined.
module btb_entry_ram
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [29-IDX_W:0] rd_tag_o,
    output logic [31:0]       rd_target_o,
`ifdef BTB_BHT_EN
    output logic [1:0]        rd_ctr_o,
`endif
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [29-IDX_W:0] wr_tag_i,
    input  logic [31:0]       wr_target_i,
    input  logic              wr_insert_i,
    input  logic              wr_inval_i,
    output logic              wr_match_o
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign wr_match_o  = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

    always_comb begin
        valid_d = valid_q;
        if (wr_insert_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
`ifndef BTB_BHT_EN
        else if (wr_inval_i && wr_match_o) begin
            valid_d[wr_idx_i] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/target are written even under reset: the cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (wr_insert_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

`ifdef BTB_BHT_EN
    bht_ctr_t ctr_q [DEPTH];
    bht_ctr_t ctr_wr_d;
    logic     ctr_we;

    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        ctr_wr_d = ctr_q[wr_idx_i];
        ctr_we   = 1'b0;
        if (wr_insert_i) begin
            ctr_we   = 1'b1;
            ctr_wr_d = wr_match_o ? bht_inc(ctr_q[wr_idx_i]) : BHT_CTR_INS;
        end else if (wr_inval_i && wr_match_o) begin
            ctr_we   = 1'b1;
            ctr_wr_d = bht_dec(ctr_q[wr_idx_i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= BHT_CTR_RST;
            end
        end else if (ctr_we) begin
            ctr_q[wr_idx_i] <= ctr_wr_d;
        end
    end
`endif

endmodule

// File: rtl/btb_predictor.sv
// IF-stage branch target buffer: lookup of the fetch PC, EX-stage updates and a
// saturating correction counter. Define BTB_BHT_EN for 2-bit direction counters.
module btb_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_npc,
    input  logic [1:0]       btb_cmd,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    output logic [CNT_W-1:0] corr_cnt
);

    logic [IDX_W-1:0]  if_idx;
    logic [29-IDX_W:0] if_tag;
    logic [IDX_W-1:0]  ex_idx;
    logic [29-IDX_W:0] ex_tag;
    logic              rd_valid;
    logic [29-IDX_W:0] rd_tag;
    logic [31:0]       rd_target;
    logic              hit;
    logic              is_insert;
    logic              is_inval;
    logic              wr_match;
    logic              corr_inc;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              unused_lsb;

    assign if_idx     = if_pc[IDX_W+1:2];
    assign if_tag     = if_pc[31:IDX_W+2];
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign ex_tag     = ex_pc[31:IDX_W+2];
    assign unused_lsb = ^{if_pc[1:0], ex_pc[1:0]};

    assign is_insert = (btb_cmd == BTB_CMD_INSERT);
    assign is_inval  = (btb_cmd == BTB_CMD_INVAL);

`ifdef BTB_BHT_EN
    logic [1:0] rd_ctr;
`endif

    btb_entry_ram #(
        .IDX_W(IDX_W)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (if_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
`ifdef BTB_BHT_EN
        .rd_ctr_o    (rd_ctr),
`endif
        .wr_idx_i    (ex_idx),
        .wr_tag_i    (ex_tag),
        .wr_target_i (ex_target),
        .wr_insert_i (is_insert),
        .wr_inval_i  (is_inval),
        .wr_match_o  (wr_match)
    );

    assign hit = rd_valid && (rd_tag == if_tag);

`ifdef BTB_BHT_EN
    assign pred_taken = hit && rd_ctr[1];
`else
    assign pred_taken = hit;
`endif

    assign pred_npc = pred_taken ? rd_target : if_pc + PC_STEP;

    assign corr_inc = is_insert || (is_inval && wr_match);

    always_comb begin
        cnt_d = cnt_q;
        if (corr_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign corr_cnt = cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: a word-addressed reference table predicts
// each cycle's outputs, a negedge monitor compares them.
module tb_btb_predictor;

    localparam int IDX_W = 6;
    localparam int CNT_W = 16;
    localparam int DEPTH = 64;
    localparam int unsigned CNT_MAX = 65535;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_npc;
    logic [1:0]       btb_cmd;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic [CNT_W-1:0] corr_cnt;

    always #5 clk = ~clk;

    btb_predictor #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc      (if_pc),
        .pred_taken (pred_taken),
        .pred_npc   (pred_npc),
        .btb_cmd    (btb_cmd),
        .ex_pc      (ex_pc),
        .ex_target  (ex_target),
        .corr_cnt   (corr_cnt)
    );

    typedef struct {
        logic             taken;
        logic [31:0]      npc;
        logic [CNT_W-1:0] cnt;
        logic [31:0]      pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: each slot remembers the full word address of its branch.
    bit          m_valid  [DEPTH];
    bit [29:0]   m_word   [DEPTH];
    bit [31:0]   m_target [DEPTH];
    int          m_ctr    [DEPTH];
    int unsigned m_cnt;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit hits(input logic [31:0] pc);
        int s = slot_of(pc);
        return m_valid[s] && (m_word[s] == pc[31:2]);
    endfunction

    function automatic exp_t predict(input logic [31:0] pc);
        exp_t e;
        int   s = slot_of(pc);
        bit   tk = hits(pc);
`ifdef BTB_BHT_EN
        tk = tk && (m_ctr[s] >= 2);
`endif
        e.taken = tk;
        e.npc   = tk ? m_target[s] : pc + 32'd4;
        e.cnt   = CNT_W'(m_cnt);
        e.pc    = pc;
        return e;
    endfunction

    function automatic void bump_cnt();
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    endfunction

    function automatic void apply(input bit r, input logic [1:0] cmd,
                                  input logic [31:0] ex, input logic [31:0] tgt);
        int s = slot_of(ex);
        bit match = hits(ex);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_cnt = 0;
        end else if (cmd == 2'b10) begin
`ifdef BTB_BHT_EN
            m_ctr[s] = match ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : 2;
`endif
            m_valid[s]  = 1'b1;
            m_word[s]   = ex[31:2];
            m_target[s] = tgt;
            bump_cnt();
        end else if (cmd == 2'b01 && match) begin
`ifdef BTB_BHT_EN
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
`else
            m_valid[s] = 1'b0;
`endif
            bump_cnt();
        end
    endfunction

    task automatic step(input bit r, input logic [1:0] cmd, input logic [31:0] ex,
                        input logic [31:0] tgt, input logic [31:0] pc, input bit chk);
        rst       = r;
        btb_cmd   = cmd;
        ex_pc     = ex;
        ex_target = tgt;
        if_pc     = pc;
        if (chk) exp_q.push_back(predict(pc));
        apply(r, cmd, ex, tgt);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [23:0] tg;
        logic [5:0]  ix;
        case ($urandom % 4)
            0: ix = 6'd0;
            1: ix = 6'd1;
            2: ix = 6'd31;
            default: ix = 6'd63;
        endcase
        case ($urandom % 4)
            0: tg = 24'h000000;
            1: tg = 24'h000001;
            2: tg = 24'h000002;
            default: tg = 24'hFFFFFF;
        endcase
        return {tg, ix, 2'($urandom)};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pred_taken !== e.taken) begin
                errors++;
                $display("FAIL pred_taken pc=%08h got %b want %b", e.pc, pred_taken, e.taken);
            end
            checks++;
            if (pred_npc !== e.npc) begin
                errors++;
                $display("FAIL pred_npc pc=%08h got %08h want %08h", e.pc, pred_npc, e.npc);
            end
            checks++;
            if (corr_cnt !== e.cnt) begin
                errors++;
                $display("FAIL corr_cnt pc=%08h got %0d want %0d", e.pc, corr_cnt, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_cnt = 0;
        step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset state, then insert with same-cycle lookup (old contents visible).
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b10, 32'h0000_0100, 32'h0000_0040, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0100, 1'b1);

        // Aliasing at idx 0: different tag misses, non-matching invalidate is ignored.
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0200, 1'b1);
        step(1'b0, 2'b01, 32'h0000_0200, 32'h0, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0100, 1'b1);

        // Refresh with a new target, no bypass; then fetch wrap on a miss.
        step(1'b0, 2'b10, 32'h0000_0100, 32'h0000_0080, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b11, 32'h0000_0100, 32'h0, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0100, 1'b1);

        // Matching invalidate, then insert / invalidate / insert x2 for the counter path.
        step(1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b10, 32'h0000_0300, 32'h0000_1000, 32'h0000_0300, 1'b1);
        step(1'b0, 2'b01, 32'h0000_0300, 32'h0, 32'h0000_0300, 1'b1);
        step(1'b0, 2'b10, 32'h0000_0300, 32'h0000_2000, 32'h0000_0300, 1'b1);
        step(1'b0, 2'b10, 32'h0000_0300, 32'h0000_3000, 32'h0000_0300, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0300, 1'b1);

        // Reset wins over a simultaneous insert.
        step(1'b1, 2'b10, 32'h0000_0300, 32'h0000_0010, 32'h0000_0300, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0300, 1'b1);

        // Drive the correction counter into saturation and past it.
        for (int i = 0; i < 65540; i++) begin
            step(1'b0, 2'b10, rand_pc(), $urandom, rand_pc(), 1'b1);
        end
        step(1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h0000_0100, 1'b1);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0000_0100, 1'b1);

        // Randomized mix including 2'b11 and occasional resets.
        step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 50) == 0, 2'($urandom), rand_pc(), $urandom, rand_pc(), 1'b1);
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
